// File: rtl/fetch_target_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_target_queue
// Purpose  : Circular buffer of BPU predictions (block PC, next PC, taken
//            slot) presented in order to the IFU. A backend flush drops
//            every queued prediction.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_target_queue #(
    parameter int XLEN            = 32,
    parameter int INSTR_PER_FETCH = 4,
    parameter int DEPTH           = 8
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               flush_i,
    input  logic                               enq_valid_i,
    output logic                               enq_ready_o,
    input  logic [XLEN-1:0]                    enq_pc_i,
    input  logic [XLEN-1:0]                    enq_npc_i,
    input  logic                               enq_slot_valid_i,
    input  logic [$clog2(INSTR_PER_FETCH)-1:0] enq_slot_idx_i,
    input  logic [XLEN-1:0]                    enq_slot_target_i,
    output logic                               deq_valid_o,
    input  logic                               deq_ready_i,
    output logic [XLEN-1:0]                    deq_pc_o,
    output logic [XLEN-1:0]                    deq_npc_o,
    output logic                               deq_slot_valid_o,
    output logic [$clog2(INSTR_PER_FETCH)-1:0] deq_slot_idx_o,
    output logic [XLEN-1:0]                    deq_slot_target_o,
    output logic [$clog2(DEPTH)-1:0]           deq_idx_o,
    output logic [$clog2(DEPTH):0]             count_o
);

    localparam int SLOT_W = $clog2(INSTR_PER_FETCH);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    // Entry storage; deliberately not reset, only pointers define validity
    logic [XLEN-1:0]   pc_mem     [DEPTH];
    logic [XLEN-1:0]   npc_mem    [DEPTH];
    logic              sv_mem     [DEPTH];
    logic [SLOT_W-1:0] sidx_mem   [DEPTH];
    logic [XLEN-1:0]   target_mem [DEPTH];

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              enq_fire;
    logic              deq_fire;

    // Handshakes decoded from registered count only; flush suppresses both
    always_comb begin
        enq_ready_o = (count != FULL_COUNT);
        deq_valid_o = (count != '0);
        enq_fire    = enq_valid_i && enq_ready_o && !flush_i;
        deq_fire    = deq_valid_o && deq_ready_i && !flush_i;
    end

    // Pointer and occupancy update; flush clears everything ahead of handshakes
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq_fire) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (deq_fire) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({enq_fire, deq_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Write the offered prediction into the tail slot when accepted
    always_ff @(posedge clk_i) begin
        if (enq_fire) begin
            pc_mem[wr_ptr]     <= enq_pc_i;
            npc_mem[wr_ptr]    <= enq_npc_i;
            sv_mem[wr_ptr]     <= enq_slot_valid_i;
            sidx_mem[wr_ptr]   <= enq_slot_idx_i;
            target_mem[wr_ptr] <= enq_slot_target_i;
        end
    end

    // Head entry is read straight from storage; stable while the IFU stalls
    always_comb begin
        deq_pc_o          = pc_mem[rd_ptr];
        deq_npc_o         = npc_mem[rd_ptr];
        deq_slot_valid_o  = sv_mem[rd_ptr];
        deq_slot_idx_o    = sidx_mem[rd_ptr];
        deq_slot_target_o = target_mem[rd_ptr];
        deq_idx_o         = rd_ptr;
        count_o           = count;
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_target_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_target_queue
// Purpose  : Self-checking bench for fetch_target_queue: vector table for
//            fill/drain, hand sequences for corner cases, random traffic
//            against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_target_queue;

    localparam int DEPTH = 8;
    localparam logic [31:0] BASE = 32'h8000_0000;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] npc;
        logic        sv;
        logic [1:0]  sidx;
        logic [31:0] st;
    } ent_t;

    typedef struct {
        logic        ev;
        logic        dr;
        logic [31:0] pc;
        int          exp_count;
        logic        exp_dv;
        logic        exp_er;
        logic [31:0] exp_pc;
        int          exp_idx;
    } vec_t;

    logic        clk, rst, flush, enq_valid, deq_ready;
    logic [31:0] enq_pc, enq_npc, enq_st;
    logic        enq_sv;
    logic [1:0]  enq_sidx;
    logic        enq_ready, deq_valid, deq_sv;
    logic [31:0] deq_pc, deq_npc, deq_st;
    logic [1:0]  deq_sidx;
    logic [2:0]  deq_idx;
    logic [3:0]  count;

    int checks = 0;
    int errors = 0;

    ent_t q[$];
    int   rd_idx = 0;

    fetch_target_queue #(.XLEN(32), .INSTR_PER_FETCH(4), .DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .enq_valid_i(enq_valid), .enq_ready_o(enq_ready),
        .enq_pc_i(enq_pc), .enq_npc_i(enq_npc),
        .enq_slot_valid_i(enq_sv), .enq_slot_idx_i(enq_sidx),
        .enq_slot_target_i(enq_st),
        .deq_valid_o(deq_valid), .deq_ready_i(deq_ready),
        .deq_pc_o(deq_pc), .deq_npc_o(deq_npc),
        .deq_slot_valid_o(deq_sv), .deq_slot_idx_o(deq_sidx),
        .deq_slot_target_o(deq_st), .deq_idx_o(deq_idx), .count_o(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic ent_t mk(input logic [31:0] pc);
        ent_t e;
        e.pc   = pc;
        e.npc  = pc + 32'd16;
        e.sv   = 1'($urandom_range(0, 1));
        e.sidx = 2'($urandom_range(0, 3));
        e.st   = $urandom;
        return e;
    endfunction

    task automatic check_model();
        chk("count", 64'(count), 64'(q.size()));
        chk("deq_valid", 64'(deq_valid), 64'(q.size() != 0));
        chk("enq_ready", 64'(enq_ready), 64'(q.size() != DEPTH));
        chk("deq_idx", 64'(deq_idx), 64'(rd_idx));
        if (q.size() != 0) begin
            chk("deq_pc", 64'(deq_pc), 64'(q[0].pc));
            chk("deq_npc", 64'(deq_npc), 64'(q[0].npc));
            chk("deq_slot_valid", 64'(deq_sv), 64'(q[0].sv));
            chk("deq_slot_idx", 64'(deq_sidx), 64'(q[0].sidx));
            chk("deq_slot_target", 64'(deq_st), 64'(q[0].st));
        end
    endtask

    // One clock of traffic, then advance the reference model and compare
    task automatic cycle(input logic f, input logic ev, input logic dr, input ent_t e);
        bit ef, df;
        flush = f; enq_valid = ev; deq_ready = dr;
        enq_pc = e.pc; enq_npc = e.npc; enq_sv = e.sv; enq_sidx = e.sidx; enq_st = e.st;
        ef = ev && (q.size() != DEPTH) && !f;
        df = dr && (q.size() != 0) && !f;
        @(posedge clk); #1;
        if (f) begin
            q.delete();
            rd_idx = 0;
        end else begin
            if (df) begin
                void'(q.pop_front());
                rd_idx = (rd_idx + 1) % DEPTH;
            end
            if (ef) q.push_back(e);
        end
        check_model();
    endtask

    task automatic drain();
        while (q.size() != 0) cycle(1'b0, 1'b0, 1'b1, mk(32'h0));
    endtask

    vec_t tbl[17];
    bit   saw_wrap;
    logic [2:0] prev_idx;
    ent_t e;

    initial begin
        // vector table: fill past full, then drain in order
        for (int i = 0; i < 9; i++) begin
            tbl[i].ev = 1'b1; tbl[i].dr = 1'b0;
            tbl[i].pc = BASE + 32'(16 * i);
            tbl[i].exp_count = (i < 8) ? i + 1 : 8;
            tbl[i].exp_dv = 1'b1;
            tbl[i].exp_er = (i < 7);
            tbl[i].exp_pc = BASE;
            tbl[i].exp_idx = 0;
        end
        for (int k = 0; k < 8; k++) begin
            tbl[9+k].ev = 1'b0; tbl[9+k].dr = 1'b1;
            tbl[9+k].pc = 32'h0;
            tbl[9+k].exp_count = 7 - k;
            tbl[9+k].exp_dv = (k < 7);
            tbl[9+k].exp_er = 1'b1;
            tbl[9+k].exp_pc = BASE + 32'(16 * (k + 1));
            tbl[9+k].exp_idx = (k + 1) % 8;
        end

        rst = 1'b1; flush = 1'b0; enq_valid = 1'b0; deq_ready = 1'b0;
        enq_pc = '0; enq_npc = '0; enq_sv = 1'b0; enq_sidx = '0; enq_st = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_deq_valid", 64'(deq_valid), 64'd0);
        chk("rst_enq_ready", 64'(enq_ready), 64'd1);
        chk("rst_deq_idx", 64'(deq_idx), 64'd0);
        rst = 1'b0;

        // idle with deq_ready high must not move anything
        repeat (3) cycle(1'b0, 1'b0, 1'b1, mk(32'h0));

        // table-driven fill and drain
        for (int i = 0; i < 17; i++) begin
            flush = 1'b0; enq_valid = tbl[i].ev; deq_ready = tbl[i].dr;
            enq_pc = tbl[i].pc; enq_npc = tbl[i].pc + 32'd16;
            enq_sv = 1'b1; enq_sidx = 2'd2; enq_st = 32'h8000_1234;
            @(posedge clk); #1;
            chk("tbl_count", 64'(count), 64'(tbl[i].exp_count));
            chk("tbl_deq_valid", 64'(deq_valid), 64'(tbl[i].exp_dv));
            chk("tbl_enq_ready", 64'(enq_ready), 64'(tbl[i].exp_er));
            chk("tbl_deq_idx", 64'(deq_idx), 64'(tbl[i].exp_idx));
            if (tbl[i].exp_dv) begin
                chk("tbl_deq_pc", 64'(deq_pc), 64'(tbl[i].exp_pc));
                chk("tbl_deq_npc", 64'(deq_npc), 64'(tbl[i].exp_pc + 32'd16));
                chk("tbl_slot_idx", 64'(deq_sidx), 64'd2);
                chk("tbl_slot_target", 64'(deq_st), 64'h8000_1234);
            end
        end
        // model now matches: empty, head pointer back at 0
        q.delete(); rd_idx = 0;

        // full queue: simultaneous enq+deq, enq must be refused
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 1'b0, mk(32'h9000_0000 + 32'(16 * i)));
        cycle(1'b0, 1'b1, 1'b1, mk(32'hDEAD_0000));
        drain();

        // steady state at count 3 with pointer wrap
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, mk(32'hA000_0000 + 32'(16 * i)));
        saw_wrap = 1'b0;
        for (int i = 0; i < 20; i++) begin
            e = mk(32'hB000_0000 + 32'(16 * i));
            if (i[0]) begin
                e.sv = 1'b1; e.sidx = 2'd2; e.st = 32'h8000_1234;
            end
            prev_idx = deq_idx;
            cycle(1'b0, 1'b1, 1'b1, e);
            if (prev_idx == 3'd7 && deq_idx == 3'd0) saw_wrap = 1'b1;
        end
        chk("idx_wrap_seen", 64'(saw_wrap), 64'd1);
        drain();

        // flush with simultaneous enq and deq at count 5
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0, mk(32'hC000_0000 + 32'(16 * i)));
        cycle(1'b1, 1'b1, 1'b1, mk(32'hF1F1_F1F0));
        cycle(1'b0, 1'b1, 1'b0, mk(32'h0000_4000));
        drain();

        // async reset between edges at count 4
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, mk(32'hD000_0000 + 32'(16 * i)));
        rst = 1'b1; flush = 1'b1; enq_valid = 1'b1; deq_ready = 1'b1;
        #2;
        chk("async_rst_count", 64'(count), 64'd0);
        chk("async_rst_deq_valid", 64'(deq_valid), 64'd0);
        chk("async_rst_enq_ready", 64'(enq_ready), 64'd1);
        chk("async_rst_deq_idx", 64'(deq_idx), 64'd0);
        q.delete(); rd_idx = 0;
        @(posedge clk); #1;
        rst = 1'b0; flush = 1'b0; enq_valid = 1'b0; deq_ready = 1'b0;
        cycle(1'b0, 1'b1, 1'b0, mk(32'h0000_0100));
        chk("post_rst_pc", 64'(deq_pc), 64'h100);
        drain();

        // randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 31) == 0),
                  1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 2) != 0),
                  mk($urandom));
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
